// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: CPU execution-rate controller driven from the board clock.
//   A prescaler produces a tick every DIV_TERM+1 clocks. In RUN each tick is
//   turned into a one-clock cpu_en strobe used as the CPU clock enable. HALT
//   and single-STEP are selected by debounced KEY presses.
//
// Ports
//   clk, reset        board clock, async active-high reset
//   key_run_n         raw KEY (active low), press toggles RUN/HALT
//   key_step_n        raw KEY (active low), press in HALT runs one instruction
//   pc_in, bp_addr    current PC / breakpoint address (breakpoint build only)
//   bp_valid          breakpoint armed (breakpoint build only)
//   cpu_en            registered one-clock advance strobe
//   running           FSM is in RUN
//   step_count        strobes issued, wraps modulo 2**CNT_W
//   heartbeat         toggles every prescaler tick
//   bp_hit            sticky breakpoint-halt flag
//
// Build option: define CPU_STEP_BREAKPOINT_EN to add the PC breakpoint.
// Without it the breakpoint inputs are ignored and bp_hit is constant 0.
module cpu_step_ctrl #(
  parameter int              DIV_W      = 32,
  parameter logic [DIV_W-1:0] DIV_TERM  = DIV_W'(2**20-1),
  parameter logic [15:0]     DEB_CYCLES = 16'd50000,
  parameter int              CNT_W      = 32,
  parameter int              PC_W       = 32,
  parameter bit              RESET_RUN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_run_n,
  input  logic             key_step_n,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] step_count,
  output logic             heartbeat,
  output logic             bp_hit
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;
  localparam state_t RST_STATE = RESET_RUN ? S_RUN : S_HALT;

  // ---------------- prescaler ----------------
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;
  logic             hb_q;

  assign tick = (div_cnt_q == DIV_TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      hb_q      <= 1'b0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) hb_q <= ~hb_q;
    end
  end

  // ---------------- key debouncers ----------------
  // Bit 0 = run key, bit 1 = step key.
  logic [1:0]       key_raw;
  logic [1:0]       sync1_q, sync2_q, lvl_q;
  logic [1:0][15:0] deb_cnt_q;
  logic [1:0]       press;

  assign key_raw = {key_step_n, key_run_n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      lvl_q     <= 2'b11;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] != lvl_q[k]) begin
          if (deb_cnt_q[k] == DEB_CYCLES - 16'd1) begin
            lvl_q[k]     <= sync2_q[k];
            deb_cnt_q[k] <= '0;
          end else begin
            deb_cnt_q[k] <= deb_cnt_q[k] + 16'd1;
          end
        end else begin
          // any sample matching the accepted level restarts the count
          deb_cnt_q[k] <= '0;
        end
      end
    end
  end

  // Press fires in the cycle the debounced level is about to fall.
  always_comb begin
    for (int k = 0; k < 2; k++)
      press[k] = lvl_q[k] & ~sync2_q[k] & (deb_cnt_q[k] == DEB_CYCLES - 16'd1);
  end

  logic press_run, press_step;
  assign press_run  = press[0];
  assign press_step = press[1];

  // ---------------- breakpoint compare ----------------
  logic bp_match;
`ifdef CPU_STEP_BREAKPOINT_EN
  logic skip_q;   // first RUN tick after leaving HALT never traps
  logic bp_hit_q;
  state_t state_q;

  assign bp_match = bp_valid && (pc_in == bp_addr) && !skip_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      if (state_q == S_HALT) skip_q <= 1'b1;
      else if (tick)         skip_q <= 1'b0;
      if (state_q == S_RUN && !press_run && tick && bp_match) bp_hit_q <= 1'b1;
      else if (press_run)                                     bp_hit_q <= 1'b0;
    end
  end
  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  state_t state_q;
  assign unused_bp = bp_valid ^ (^pc_in) ^ (^bp_addr);
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  // ---------------- control FSM ----------------
  state_t           state_d;
  logic             en_d, en_q;
  logic [CNT_W-1:0] step_count_q;

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    case (state_q)
      S_HALT: begin
        if (press_run)       state_d = S_RUN;   // run wins over a same-cycle step
        else if (press_step) state_d = S_STEP;
      end
      S_RUN: begin
        if (press_run)     state_d = S_HALT;   // the halting tick is not strobed
        else if (tick) begin
          if (bp_match)    state_d = S_HALT;
          else             en_d    = 1'b1;
        end
      end
      S_STEP: begin
        // A tick here is the step's strobe; a same-cycle run press keeps it
        // and continues in RUN so the strobe is neither dropped nor repeated.
        if (tick) en_d = 1'b1;
        if (press_run)  state_d = S_RUN;
        else if (tick)  state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RST_STATE;
      en_q         <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      if (en_d) step_count_q <= step_count_q + 1'b1;
    end
  end

  assign cpu_en     = en_q;
  assign running    = (state_q == S_RUN);
  assign step_count = step_count_q;
  assign heartbeat  = hb_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DIV_TERM=3, DEB_CYCLES=4, CNT_W=8.
module tb_cpu_step_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        key_run_n = 1'b1, key_step_n = 1'b1, bp_valid = 1'b0;
  logic [31:0] pc_in = '0, bp_addr = '0;
  logic        cpu_en, running, heartbeat, bp_hit;
  logic [7:0]  step_count;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DIV_W(32), .DIV_TERM(32'd3), .DEB_CYCLES(16'd4),
    .CNT_W(8), .PC_W(32), .RESET_RUN(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .key_run_n(key_run_n), .key_step_n(key_step_n),
    .pc_in(pc_in), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_en(cpu_en), .running(running), .step_count(step_count),
    .heartbeat(heartbeat), .bp_hit(bp_hit)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap, bad, tog, en_seen;
    logic hb_prev, seen_run, bp_at_run;
    logic [7:0] snap;

    // ---- 1: reset state and idle HALT ----
    repeat (3) cyc();
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_heartbeat", heartbeat, 0);
    chk("rst_running", running, 0);
    chk("rst_bp_hit", bp_hit, 0);
    reset = 1'b0;
    hb_prev = heartbeat; tog = 0; bad = 0; en_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      en_seen += cpu_en;
      if (heartbeat != hb_prev) begin
        tog++;
        if ((i + 1) % 4 != 0) bad++;
      end
      hb_prev = heartbeat;
    end
    chk("t1_hb_toggles", tog, 25);
    chk("t1_hb_period", bad, 0);
    chk("t1_no_cpu_en", en_seen, 0);
    chk("t1_step_count", step_count, 0);

    // ---- 2: run, 300 strobes, wrap to 44 ----
    key_run_n = 1'b0; n = 0; gap = 0; bad = 0;
    for (int i = 0; i < 3000 && n < 300; i++) begin
      cyc();
      if (i == 19) key_run_n = 1'b1;
      if (cpu_en) begin
        n++;
        if (n > 1 && gap != 3) bad++;
        gap = 0;
      end else gap++;
    end
    chk("t2_strobes", n, 300);
    chk("t2_step_wrap", step_count, 44);
    chk("t2_spacing", bad, 0);
    chk("t2_running", running, 1);
    key_run_n = 1'b0; repeat (20) cyc(); key_run_n = 1'b1; repeat (10) cyc();
    chk("t2_halted", running, 0);
    snap = step_count; en_seen = 0;
    for (int i = 0; i < 40; i++) begin cyc(); en_seen += cpu_en; end
    chk("t2_halt_quiet", en_seen, 0);
    chk("t2_halt_count", step_count, snap);

    // ---- 3: step glitch rejected, clean press steps once ----
    key_step_n = 1'b0; repeat (3) cyc(); key_step_n = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin cyc(); en_seen += cpu_en; end
    chk("t3_glitch_en", en_seen, 0);
    chk("t3_glitch_count", step_count, snap);
    key_step_n = 1'b0; en_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (i == 9) key_step_n = 1'b1;
      en_seen += cpu_en;
    end
    chk("t3_one_step", en_seen, 1);
    chk("t3_step_count", step_count, 8'(snap + 8'd1));
    chk("t3_back_halt", running, 0);

    // ---- 4: simultaneous keys -> RUN; async reset mid-strobe ----
    key_run_n = 1'b0; key_step_n = 1'b0;
    repeat (20) cyc();
    key_run_n = 1'b1; key_step_n = 1'b1;
    chk("t4_running", running, 1);
    n = 0; gap = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (cpu_en) begin
        n++;
        if (n > 1 && gap != 3) bad++;
        gap = 0;
      end else gap++;
    end
    chk("t4_strobes", n, 10);
    chk("t4_spacing", bad, 0);
    for (int i = 0; i < 10 && !cpu_en; i++) cyc();
    chk("t4_pre_rst_en", cpu_en, 1);
    reset = 1'b1; #1;
    chk("t4_rst_cpu_en", cpu_en, 0);
    chk("t4_rst_running", running, 0);
    chk("t4_rst_count", step_count, 0);
    chk("t4_rst_hb", heartbeat, 0);
    chk("t4_rst_bp_hit", bp_hit, 0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (4) cyc();

    // ---- 5/6: breakpoint at PC 0x10 ----
    bp_addr = 32'h10; bp_valid = 1'b1; pc_in = 32'h20;
    key_run_n = 1'b0; repeat (20) cyc(); key_run_n = 1'b1;
    for (int i = 0; i < 20 && !cpu_en; i++) cyc();
    chk("t5_run_strobe", cpu_en, 1);
    pc_in = 32'h10; en_seen = 0;
    for (int i = 0; i < 8; i++) begin cyc(); en_seen += cpu_en; end
`ifdef CPU_STEP_BREAKPOINT_EN
    chk("t5_trap_no_en", en_seen, 0);
    chk("t5_trap_bp_hit", bp_hit, 1);
    chk("t5_trap_halt", running, 0);
    key_run_n = 1'b0; n = 0; seen_run = 1'b0; bp_at_run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (i == 19) key_run_n = 1'b1;
      if (running && !seen_run) begin seen_run = 1'b1; bp_at_run = bp_hit; end
      n += cpu_en;
    end
    chk("t5_resumed", seen_run, 1);
    chk("t5_bp_cleared", bp_at_run, 0);
    chk("t5_one_en", n, 1);
    chk("t5_retrap_bp", bp_hit, 1);
    chk("t5_retrap_halt", running, 0);
`else
    chk("t6_no_trap_en", en_seen, 2);
    chk("t6_bp_hit", bp_hit, 0);
    chk("t6_running", running, 1);
    en_seen = 0;
    for (int i = 0; i < 40; i++) begin cyc(); en_seen += cpu_en; end
    chk("t6_every_tick", en_seen, 10);
    chk("t6_bp_hit_end", bp_hit, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
